// File: rtl/add_arbiter_pkg.sv
// ============================================================================
//  Module      : add_arbiter_pkg
//  Description : Shared FSM state encoding and default parameter constants
//                for the round-robin arbitrated adder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package add_arbiter_pkg;

  // Controller states; encoding is fixed so debug views stay stable.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_NUMBER_OF_BITS       = 8;
  localparam int DEFAULT_NUMBER_OF_REQUESTERS = 4;
  localparam int DEFAULT_ADD_LATENCY          = 2;

endpackage

`default_nettype wire

// File: rtl/add_arbiter_add_core.sv
// ============================================================================
//  Module      : add_core
//  Description : Combinational unsigned adder. Wraps modulo 2^numberOfBits by
//                default; saturates to all ones on carry-out when the macro
//                ADD_ARBITER_SAT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_core
  import add_arbiter_pkg::*;
#(
  parameter int numberOfBits = DEFAULT_NUMBER_OF_BITS
) (
  input  logic [numberOfBits-1:0] left_i,
  input  logic [numberOfBits-1:0] right_i,
  output logic [numberOfBits-1:0] sum_o
);

`ifdef ADD_ARBITER_SAT_EN
  // One extra bit exposes the carry so overflow can clamp the result.
  logic [numberOfBits:0] w_fullSum;
  assign w_fullSum = {1'b0, left_i} + {1'b0, right_i};
  assign sum_o     = w_fullSum[numberOfBits] ? {numberOfBits{1'b1}}
                                             : w_fullSum[numberOfBits-1:0];
`else
  // Natural truncation gives the modulo wrap.
  assign sum_o = left_i + right_i;
`endif

endmodule

`default_nettype wire

// File: rtl/add_arbiter.sv
// ============================================================================
//  Module      : add_arbiter
//  Description : Round-robin arbiter in front of a shared multi-cycle adder.
//                One requester is accepted at a time; its operands are held
//                for addLatency cycles, then the sum and owner index are
//                presented until the consumer accepts them.
//                Optional macro: ADD_ARBITER_SAT_EN (saturating sum).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int numberOfBits       = DEFAULT_NUMBER_OF_BITS,
  parameter int numberOfRequesters = DEFAULT_NUMBER_OF_REQUESTERS,
  parameter int addLatency         = DEFAULT_ADD_LATENCY
) (
  input  logic                                       clock,
  input  logic                                       nReset,
  input  logic [numberOfRequesters-1:0]              reqValid,
  input  logic [numberOfRequesters*numberOfBits-1:0] reqLeft,
  input  logic [numberOfRequesters*numberOfBits-1:0] reqRight,
  output logic [numberOfRequesters-1:0]              reqReady,
  output logic                                       resValid,
  output logic [numberOfBits-1:0]                    resData,
  output logic [$clog2(numberOfRequesters)-1:0]      resOwner,
  input  logic                                       resReady
);

  localparam int OWNER_W = $clog2(numberOfRequesters);
  localparam int CNT_W   = (addLatency > 1) ? $clog2(addLatency) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(addLatency - 1);

  state_e                 state_q;
  logic [CNT_W-1:0]       busyCnt_q;
  logic [OWNER_W-1:0]     lastGrant_q;   // also the owner of the in-flight sum
  logic [numberOfBits-1:0] opLeft_q;
  logic [numberOfBits-1:0] opRight_q;
  logic                    resValid_q;
  logic [numberOfBits-1:0] resData_q;
  logic [OWNER_W-1:0]      resOwner_q;

  logic [OWNER_W-1:0]      w_winner;
  logic                    w_anyValid;
  logic [numberOfBits-1:0] w_selLeft;
  logic [numberOfBits-1:0] w_selRight;
  logic [numberOfBits-1:0] w_sum;
  int                      w_idx;

  // Cyclic priority search starting just after the last granted requester.
  always_comb begin
    w_winner   = '0;
    w_anyValid = 1'b0;
    w_idx      = 0;
    for (int k = 1; k <= numberOfRequesters; k++) begin
      w_idx = int'(lastGrant_q) + k;
      if (w_idx >= numberOfRequesters) w_idx = w_idx - numberOfRequesters;
      if (!w_anyValid && reqValid[w_idx[OWNER_W-1:0]]) begin
        w_anyValid = 1'b1;
        w_winner   = w_idx[OWNER_W-1:0];
      end
    end
  end

  // Grant is only offered while idle, so at most one bit is ever set.
  always_comb begin
    reqReady = '0;
    if (state_q == IDLE && w_anyValid) reqReady[w_winner] = 1'b1;
  end

  // Operand mux for the winner; constant slices keep index widths exact.
  always_comb begin
    w_selLeft  = '0;
    w_selRight = '0;
    for (int i = 0; i < numberOfRequesters; i++) begin
      if (w_winner == OWNER_W'(i)) begin
        w_selLeft  = reqLeft[i*numberOfBits +: numberOfBits];
        w_selRight = reqRight[i*numberOfBits +: numberOfBits];
      end
    end
  end

  add_core #(
    .numberOfBits (numberOfBits)
  ) u_add_core (
    .left_i  (opLeft_q),
    .right_i (opRight_q),
    .sum_o   (w_sum)
  );

  // Controller: capture on grant, count out the adder latency, hold result.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      busyCnt_q   <= '0;
      lastGrant_q <= OWNER_W'(numberOfRequesters - 1);
      opLeft_q    <= '0;
      opRight_q   <= '0;
      resValid_q  <= 1'b0;
      resData_q   <= '0;
      resOwner_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_anyValid) begin
            opLeft_q    <= w_selLeft;
            opRight_q   <= w_selRight;
            lastGrant_q <= w_winner;
            busyCnt_q   <= CNT_LOAD;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (busyCnt_q == '0) begin
            resData_q  <= w_sum;
            resOwner_q <= lastGrant_q;
            resValid_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            busyCnt_q <= busyCnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          if (resReady) begin
            resValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resValid = resValid_q;
  assign resData  = resData_q;
  assign resOwner = resOwner_q;

endmodule

`default_nettype wire

// File: tb/tb_add_arbiter.sv
// ============================================================================
//  Module      : tb_add_arbiter
//  Description : Self-checking bench for add_arbiter: directed scenarios plus
//                randomized traffic compared against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add_arbiter;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int LAT = 2;

  logic           clock  = 1'b0;
  logic           nReset = 1'b0;
  logic [N-1:0]   reqValid = '0;
  logic [N*W-1:0] reqLeft  = '0;
  logic [N*W-1:0] reqRight = '0;
  logic [N-1:0]   reqReady;
  logic           resValid;
  logic [W-1:0]   resData;
  logic [1:0]     resOwner;
  logic           resReady = 1'b1;

  logic [N-1:0]   reqValid1 = '0;
  logic [N*W-1:0] reqLeft1  = '0;
  logic [N*W-1:0] reqRight1 = '0;
  logic [N-1:0]   reqReady1;
  logic           resValid1;
  logic [W-1:0]   resData1;
  logic [1:0]     resOwner1;
  logic           resReady1 = 1'b1;

  always #5 clock = ~clock;

  add_arbiter #(.numberOfBits(W), .numberOfRequesters(N), .addLatency(LAT)) u_dut (
    .clock(clock), .nReset(nReset), .reqValid(reqValid), .reqLeft(reqLeft),
    .reqRight(reqRight), .reqReady(reqReady), .resValid(resValid),
    .resData(resData), .resOwner(resOwner), .resReady(resReady)
  );

  add_arbiter #(.numberOfBits(W), .numberOfRequesters(N), .addLatency(1)) u_dut1 (
    .clock(clock), .nReset(nReset), .reqValid(reqValid1), .reqLeft(reqLeft1),
    .reqRight(reqRight1), .reqReady(reqReady1), .resValid(resValid1),
    .resData(resData1), .resOwner(resOwner1), .resReady(resReady1)
  );

  int nChecks = 0;
  int nPass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Unsigned sum as the consumer should see it.
  function automatic int unsigned ref_sum(input int unsigned a, input int unsigned b);
    int unsigned s;
    s = a + b;
`ifdef ADD_ARBITER_SAT_EN
    if (s > (1 << W) - 1) return (1 << W) - 1;
`endif
    return s % (1 << W);
  endfunction

  // Transaction-level model: one outstanding operation stamped with its
  // acceptance cycle; the result is due LAT+1 cycles later until consumed.
  bit           m_busy = 1'b0;
  int           m_hs, m_owner, m_sum;
  int           m_last = N - 1;
  int           cyc = 0;
  int           mWin, mIdx;
  bit           mFound, expValid;
  logic [N-1:0] expReady;

  always @(negedge clock) begin
    cyc++;
    if (!nReset) begin
      m_busy = 1'b0;
      m_last = N - 1;
      chk("rst_resValid", resValid, 0);
      chk("rst_resData", resData, 0);
      chk("rst_resOwner", resOwner, 0);
    end else begin
      mFound = 1'b0;
      mWin   = 0;
      for (int k = 1; k <= N; k++) begin
        mIdx = (m_last + k) % N;
        if (!mFound && reqValid[mIdx]) begin
          mFound = 1'b1;
          mWin   = mIdx;
        end
      end
      expReady = '0;
      if (!m_busy && mFound) expReady[mWin] = 1'b1;
      expValid = m_busy && (cyc >= m_hs + LAT + 1);
      chk("model_reqReady", reqReady, expReady);
      chk("model_resValid", resValid, expValid);
      if (expValid) begin
        chk("model_resData", resData, m_sum);
        chk("model_resOwner", resOwner, m_owner);
      end
      if (!m_busy && mFound) begin
        m_busy  = 1'b1;
        m_hs    = cyc;
        m_owner = mWin;
        m_last  = mWin;
        m_sum   = ref_sum(reqLeft[mWin*W +: W], reqRight[mWin*W +: W]);
      end else if (expValid && resReady) begin
        m_busy = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    tick();
    nReset = 1'b1;
  endtask

  int grants[5];
  int expG[5] = '{0, 1, 2, 3, 0};
  int nG;
  int waitCnt;
  int expOvf;

  initial begin
`ifdef ADD_ARBITER_SAT_EN
    expOvf = 255;
`else
    expOvf = 44;
`endif
    // Reset state
    tick();
    tick();
    #1;
    chk("reset_resValid", resValid, 0);
    chk("reset_resData", resData, 0);
    chk("reset_resOwner", resOwner, 0);
    chk("reset_reqReady", reqReady, 0);
    tick();
    nReset = 1'b1;

    // req0: 3 + 4
    reqValid = 4'b0001;
    reqLeft[7:0] = 8'd3;
    reqRight[7:0] = 8'd4;
    #1;
    chk("first_reqReady", reqReady, 4'b0001);
    tick();
    reqValid = '0;
    #1 chk("first_noValid_T1", resValid, 0);
    tick();
    #1 chk("first_noValid_T2", resValid, 0);
    tick();
    #1;
    chk("first_resValid_T3", resValid, 1);
    chk("first_resData", resData, 7);
    chk("first_resOwner", resOwner, 0);
    tick();

    // All requesters valid continuously: round-robin order
    do_reset();
    reqValid = '1;
    for (int i = 0; i < N; i++) begin
      reqLeft[i*W +: W]  = 8'(i * 10 + 1);
      reqRight[i*W +: W] = 8'(i + 2);
    end
    nG = 0;
    for (int c = 0; c < 80 && nG < 5; c++) begin
      #1;
      if (reqReady != '0) begin
        chk("rr_onehot", $onehot(reqReady), 1);
        for (int b = 0; b < N; b++) if (reqReady[b]) grants[nG] = b;
        nG++;
      end
      tick();
    end
    chk("rr_grant_count", nG, 5);
    for (int g = 0; g < 5; g++) chk($sformatf("rr_grant%0d", g), grants[g], expG[g]);
    reqValid = '0;
    repeat (6) tick();

    // Overflow on req1 with consumer stalling in DONE
    do_reset();
    reqValid = 4'b0010;
    reqLeft[15:8]  = 8'd200;
    reqRight[15:8] = 8'd100;
    resReady = 1'b0;
    #1 chk("ovf_reqReady", reqReady, 4'b0010);
    tick();
    reqValid = '0;
    waitCnt = 0;
    while (resValid !== 1'b1 && waitCnt < 10) begin
      tick();
      waitCnt++;
    end
    chk("ovf_resValid", resValid, 1);
    chk("ovf_resData", resData, expOvf);
    chk("ovf_resOwner", resOwner, 1);
    reqValid = '1;
    for (int h = 0; h < 5; h++) begin
      tick();
      chk("hold_resValid", resValid, 1);
      chk("hold_resData", resData, expOvf);
      chk("hold_resOwner", resOwner, 1);
      chk("hold_reqReady", reqReady, 0);
    end
    resReady = 1'b1;
    tick();
    chk("release_resValid", resValid, 0);
    chk("release_regrant", reqReady, 4'b0100);
    tick();
    reqValid = '0;
    repeat (6) tick();

    // Reset during the second BUSY cycle
    reqValid = 4'b1000;
    reqLeft[31:24]  = 8'd20;
    reqRight[31:24] = 8'd30;
    #1 chk("midrst_reqReady", reqReady, 4'b1000);
    tick();
    reqValid = '0;
    tick();
    nReset = 1'b0;
    #1;
    chk("midrst_resValid", resValid, 0);
    chk("midrst_resData", resData, 0);
    tick();
    nReset = 1'b1;
    reqValid = '1;
    #1;
    chk("midrst_noResult", resValid, 0);
    chk("midrst_grant0", reqReady, 4'b0001);
    tick();
    reqValid = '0;
    waitCnt = 0;
    while (resValid !== 1'b1 && waitCnt < 10) begin
      tick();
      waitCnt++;
    end
    chk("midrst_next_valid", resValid, 1);
    chk("midrst_next_owner", resOwner, 0);
    repeat (3) tick();

    // Latency-1 instance: req2, 10 + 5
    reqValid1 = 4'b0100;
    reqLeft1[23:16]  = 8'd10;
    reqRight1[23:16] = 8'd5;
    #1 chk("lat1_reqReady", reqReady1, 4'b0100);
    tick();
    reqValid1 = '0;
    #1 chk("lat1_busy_noValid", resValid1, 0);
    tick();
    #1;
    chk("lat1_resValid", resValid1, 1);
    chk("lat1_resData", resData1, 15);
    chk("lat1_resOwner", resOwner1, 2);
    tick();

    // Randomized traffic against the model
    for (int r = 0; r < 400; r++) begin
      reqValid = 4'($urandom_range(0, 15));
      reqLeft  = $urandom;
      reqRight = $urandom;
      resReady = ($urandom_range(0, 3) != 0);
      tick();
    end
    reqValid = '0;
    resReady = 1'b1;
    repeat (6) tick();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
